// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with registered
// single-cycle rise/fall strobes derived from the synchronized value.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Synchronizer chain, previous-value flop and registered edge strobes.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      chain_r <= {STAGES{1'b0}};
      prev_r  <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], sig_i};
      prev_r  <= chain_r[STAGES-1];
      rise_o  <= chain_r[STAGES-1] & ~prev_r;
      fall_o  <= ~chain_r[STAGES-1] & prev_r;
    end
  end

  assign sync_o = chain_r[STAGES-1];

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input in clk_i cycles and
// presents each result on a valid/ready port, with timeout and overrun flags.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             timeout_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  meas_state_t      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] high_r, high_nxt_s;
  logic             result_s;
  logic             timeout_s;
  logic             rise_s, fall_s;
  logic             sync_unused_s;
  logic             load_s, drop_s, accept_s;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst    (rst),
    .sig_i  (sig_i),
    .sync_o (sync_unused_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Measurement FSM next state, counter and high-time capture.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    high_nxt_s  = high_r;
    result_s    = 1'b0;
    timeout_s   = 1'b0;
    if (!en_i) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = ARM;
          cnt_nxt_s   = CNT_ZERO;
        end
        ARM: begin
          if (rise_s) begin
            state_nxt_s = MEASURE;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        MEASURE: begin
          // A rise at the all-ones count is still a legal result, not a timeout.
          if (rise_s) begin
            result_s  = 1'b1;
            cnt_nxt_s = CNT_ONE;
          end else if (cnt_r == CNT_MAX) begin
            timeout_s   = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ARM;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            if (fall_s) begin
              high_nxt_s = cnt_r;
            end else begin
              high_nxt_s = high_r;
            end
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state, counter and high-time registers.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      high_r  <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      high_r  <= high_nxt_s;
    end
  end

  // Acceptance frees the slot in the same cycle a new result may load.
  assign accept_s = valid_o & ready_i;
  assign load_s   = result_s & (~valid_o | ready_i);
  assign drop_s   = result_s & valid_o & ~ready_i;

  // Output port registers: result slot, timeout pulse and sticky overrun.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      period_o  <= CNT_ZERO;
      high_o    <= CNT_ZERO;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      timeout_o <= timeout_s;
      if (load_s) begin
        period_o <= cnt_r;
        high_o   <= high_r;
        valid_o  <= 1'b1;
      end else if (accept_s) begin
        valid_o  <= 1'b0;
      end else begin
        valid_o  <= valid_o;
      end
      if (!en_i) begin
        overrun_o <= 1'b0;
      end else if (drop_s) begin
        overrun_o <= 1'b1;
      end else begin
        overrun_o <= overrun_o;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table-driven waveforms with a
// result scoreboard, plus hand sequences for backpressure, timeout and reset.
module tb_clk_period_meter;

  localparam int CW = 4;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst;
  logic          en_i;
  logic          sig_i;
  logic          ready_i;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          timeout_o;
  logic          overrun_o;

  always #5 clk_i = ~clk_i;

  clk_period_meter #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .en_i      (en_i),
    .sig_i     (sig_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .timeout_o (timeout_o),
    .overrun_o (overrun_o)
  );

  typedef struct packed {
    logic [CW-1:0] p;
    logic [CW-1:0] h;
  } res_t;

  typedef struct {
    int   high_c;
    int   low_c;
    int   n;
    res_t exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[6];
  int   checks    = 0;
  int   failures  = 0;
  int   to_count  = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Rises are driven at a negedge; every rise after the first completes one period.
  task automatic drive_periods(input int h, input int l, input int n, input res_t exp);
    for (int p = 0; p <= n; p++) begin
      sig_i = 1'b1;
      if (p > 0) exp_q.push_back(exp);
      repeat (h) tick();
      sig_i = 1'b0;
      if (p < n) repeat (l) tick();
    end
  endtask

  // Scoreboard: compare each accepted result, sampled mid-low-phase.
  initial begin
    res_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (timeout_o) to_count++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("period", int'(period_o), int'(e.p));
          check("high", int'(high_o), int'(e.h));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int first_k;
    int n_to;

    vecs[0] = '{3, 3,  3, '{4'd6,  4'd3}};
    vecs[1] = '{2, 5,  3, '{4'd7,  4'd2}};
    vecs[2] = '{2, 2,  3, '{4'd4,  4'd2}};
    vecs[3] = '{1, 1,  4, '{4'd2,  4'd1}};
    vecs[4] = '{5, 10, 2, '{4'd15, 4'd5}};
    vecs[5] = '{1, 13, 2, '{4'd14, 4'd1}};

    rst = 1'b1; en_i = 1'b0; sig_i = 1'b0; ready_i = 1'b0;
    #2;
    check("reset_outputs", int'({period_o, high_o, valid_o, timeout_o, overrun_o}), 0);
    tick(); tick();
    rst = 1'b0;

    // Disabled meter ignores a toggling input.
    ready_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      sig_i = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      #3;
      if (valid_o || timeout_o || overrun_o) seen++;
    end
    sig_i = 1'b0;
    tick();
    check("idle_quiet", seen, 0);

    for (int i = 0; i < 6; i++) begin
      en_i = 1'b1; ready_i = 1'b1;
      repeat (2) tick();
      drive_periods(vecs[i].high_c, vecs[i].low_c, vecs[i].n, vecs[i].exp);
      repeat (6) tick();
      en_i = 1'b0;
      repeat (3) tick();
      check("table_drain", exp_q.size(), 0);
    end
    check("table_no_timeout", to_count, 0);

    // Latency from the second rise at the pin to valid_o.
    en_i = 1'b1; ready_i = 1'b1;
    repeat (2) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (3) tick();
    sig_i = 1'b1; exp_q.push_back('{4'd6, 4'd3});
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) sig_i = 1'b0;
      #3;
      if (valid_o && first_k == 0) first_k = k;
    end
    check("latency", first_k, SS + 2);
    en_i = 1'b0;
    repeat (3) tick();
    check("latency_drain", exp_q.size(), 0);

    // Backpressure: first result held, later one dropped, single-cycle accept.
    en_i = 1'b1; ready_i = 1'b0;
    repeat (2) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (3) tick();
    sig_i = 1'b1; exp_q.push_back('{4'd6, 4'd3});
    repeat (2) tick(); sig_i = 1'b0; repeat (2) tick();
    sig_i = 1'b1;
    repeat (2) tick(); sig_i = 1'b0; repeat (4) tick();
    #3;
    check("bp_valid_held", int'(valid_o), 1);
    check("bp_period_held", int'(period_o), 6);
    check("bp_high_held", int'(high_o), 3);
    check("bp_overrun_set", int'(overrun_o), 1);
    tick(); ready_i = 1'b1;
    tick(); ready_i = 1'b0;
    #3;
    check("bp_valid_dropped", int'(valid_o), 0);
    check("bp_accepted", exp_q.size(), 0);
    tick(); en_i = 1'b0;
    tick(); tick();
    #3;
    check("bp_overrun_cleared", int'(overrun_o), 0);

    // A new result arriving in the acceptance cycle replaces the old one.
    en_i = 1'b1; ready_i = 1'b0;
    repeat (2) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (3) tick();
    sig_i = 1'b1; exp_q.push_back('{4'd6, 4'd3});
    repeat (2) tick(); sig_i = 1'b0; repeat (2) tick();
    sig_i = 1'b1; exp_q.push_back('{4'd4, 4'd2});
    repeat (2) tick(); sig_i = 1'b0;
    tick(); ready_i = 1'b1;
    tick(); ready_i = 1'b0;
    #3;
    check("coinc_valid", int'(valid_o), 1);
    check("coinc_period", int'(period_o), 4);
    check("coinc_high", int'(high_o), 2);
    check("coinc_no_overrun", int'(overrun_o), 0);
    tick(); ready_i = 1'b1;
    repeat (2) tick(); ready_i = 1'b0;
    en_i = 1'b0;
    repeat (2) tick();
    check("coinc_drain", exp_q.size(), 0);

    // Timeout: count hits all-ones 15 cycles after the rise strobe; pulse is registered.
    en_i = 1'b1; ready_i = 1'b1;
    repeat (2) tick();
    sig_i = 1'b1;
    first_k = 0; n_to = 0; seen = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 2) sig_i = 1'b0;
      #3;
      if (timeout_o) begin
        n_to++;
        if (first_k == 0) first_k = k;
      end
      if (valid_o) seen++;
    end
    check("to_first_cycle", first_k, 19);
    check("to_pulse_width", n_to, 1);
    check("to_no_valid", seen, 0);
    tick();
    drive_periods(2, 2, 3, '{4'd4, 4'd2});
    repeat (6) tick();
    en_i = 1'b0;
    repeat (3) tick();
    check("to_resume_drain", exp_q.size(), 0);

    // Asynchronous reset while a result is pending and a period is in progress.
    en_i = 1'b1; ready_i = 1'b0;
    repeat (2) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (3) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (2) tick();
    #1;
    check("pre_reset_valid", int'(valid_o), 1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", int'({period_o, high_o, valid_o, timeout_o, overrun_o}), 0);
    exp_q.delete();
    tick();
    rst = 1'b0; ready_i = 1'b1;
    repeat (2) tick();
    sig_i = 1'b1; repeat (3) tick(); sig_i = 1'b0; repeat (3) tick();
    #3;
    check("post_reset_one_rise", int'(valid_o), 0);
    tick();
    sig_i = 1'b1; exp_q.push_back('{4'd7, 4'd3});
    repeat (3) tick(); sig_i = 1'b0; repeat (4) tick();
    en_i = 1'b0;
    repeat (3) tick();
    check("post_reset_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
